nebula_ni_packetizer: RTL and testbench

Network-interface injection stage that sits directly upstream of one router local input port in nebula_mesh_top. It accepts a message descriptor followed by a stream of payload words. It emits one noc_flit_t per word onto local_flit_in with valid/ready: SINGLE for 1-word messages, otherwise HEAD/BODY.../TAIL. It stamps source coordinates, destination, per-packet ID and per-flit sequence number. One instance per mesh node.

---
 rtl/nebula_ni_packetizer_if.sv | 70 +++++++
 rtl/nebula_ni_packetizer.sv | 151 +++++++++++++++
 tb/tb_nebula_ni_packetizer.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nebula_ni_packetizer_if.sv
// Shared NoC types plus the packetizer's descriptor, payload and flit channels.
// Optional statistics outputs are enabled by NEBULA_NI_STATS_EN.
package nebula_pkg;
  localparam int COORD_WIDTH        = 4;
  localparam int VC_WIDTH           = 2;
  localparam int QOS_WIDTH          = 2;
  localparam int PACKET_ID_WIDTH    = 8;
  localparam int SEQ_NUM_WIDTH      = 6;
  localparam int PAYLOAD_WIDTH      = 32;
  localparam int PERF_COUNTER_WIDTH = 32;

  typedef logic [VC_WIDTH-1:0]  vc_id_t;
  typedef logic [QOS_WIDTH-1:0] qos_t;

  typedef enum logic [1:0] {
    FLIT_HEAD   = 2'd0,
    FLIT_BODY   = 2'd1,
    FLIT_TAIL   = 2'd2,
    FLIT_SINGLE = 2'd3
  } flit_type_e;

  typedef struct packed {
    flit_type_e                 flit_type;
    vc_id_t                     vc_id;
    qos_t                       qos;
    logic [COORD_WIDTH-1:0]     src_x;
    logic [COORD_WIDTH-1:0]     src_y;
    logic [COORD_WIDTH-1:0]     dst_x;
    logic [COORD_WIDTH-1:0]     dst_y;
    logic [PACKET_ID_WIDTH-1:0] packet_id;
    logic [SEQ_NUM_WIDTH-1:0]   seq_num;
    logic [PAYLOAD_WIDTH-1:0]   payload;
  } noc_flit_t;
endpackage

interface nebula_ni_packetizer_if
  import nebula_pkg::*;
#(
  parameter int LEN_WIDTH = 5
);
  logic                     msg_valid;
  logic                     msg_ready;
  logic [COORD_WIDTH-1:0]   msg_dest_x;
  logic [COORD_WIDTH-1:0]   msg_dest_y;
  vc_id_t                   msg_vc_id;
  qos_t                     msg_qos;
  logic [LEN_WIDTH-1:0]     msg_len;
  logic                     data_valid;
  logic                     data_ready;
  logic [PAYLOAD_WIDTH-1:0] data;
  logic                     flit_out_valid;
  noc_flit_t                flit_out;
  logic                     flit_out_ready;

  modport master (
    output msg_valid, msg_dest_x, msg_dest_y,
    output msg_vc_id, msg_qos, msg_len,
    output data_valid, data, flit_out_ready,
    input  msg_ready, data_ready,
    input  flit_out_valid, flit_out
  );

  modport slave (
    input  msg_valid, msg_dest_x, msg_dest_y,
    input  msg_vc_id, msg_qos, msg_len,
    input  data_valid, data, flit_out_ready,
    output msg_ready, data_ready,
    output flit_out_valid, flit_out
  );
endinterface

// File: rtl/nebula_ni_packetizer.sv
// NI injection stage: descriptor + payload words in, one noc_flit_t per word out.
// Define NEBULA_NI_STATS_EN to add saturating pkts_sent/flits_sent counters.
module nebula_ni_packetizer
  import nebula_pkg::*;
#(
  parameter logic [COORD_WIDTH-1:0] SRC_X = '0,
  parameter logic [COORD_WIDTH-1:0] SRC_Y = '0,
  parameter int MAX_LEN   = 16,
  parameter int LEN_WIDTH = 5
)(
  input  logic clk,
  input  logic rst,
  nebula_ni_packetizer_if.slave ni,
  output logic busy,
  output logic err_len_zero
`ifdef NEBULA_NI_STATS_EN
  ,
  output logic [PERF_COUNTER_WIDTH-1:0] pkts_sent,
  output logic [PERF_COUNTER_WIDTH-1:0] flits_sent
`endif
);

  typedef enum logic {IDLE, STREAM} state_t;

  localparam logic [LEN_WIDTH-1:0] MAX_L = LEN_WIDTH'(MAX_LEN);
  localparam logic [LEN_WIDTH-1:0] ONE_L = LEN_WIDTH'(1);
  localparam logic [PACKET_ID_WIDTH-1:0] ONE_P =
    PACKET_ID_WIDTH'(1);

  state_t                     state;
  logic [COORD_WIDTH-1:0]     dst_x_q;
  logic [COORD_WIDTH-1:0]     dst_y_q;
  vc_id_t                     vc_q;
  qos_t                       qos_q;
  logic [LEN_WIDTH-1:0]       len_q;
  logic [LEN_WIDTH-1:0]       cnt_q;
  logic [PACKET_ID_WIDTH-1:0] pid_q;
  noc_flit_t                  flit_q;
  logic                       vld_q;
  logic                       err_q;

  logic                 msg_fire;
  logic                 data_fire;
  logic                 out_fire;
  logic                 last;
  logic [LEN_WIDTH-1:0] eff_len;
  flit_type_e           ftype;
  noc_flit_t            nxt;

  assign ni.msg_ready  = (state == IDLE);
  assign ni.data_ready = (state == STREAM) &
                         (!vld_q | ni.flit_out_ready);
  assign ni.flit_out_valid = vld_q;
  assign ni.flit_out       = flit_q;

  assign msg_fire  = ni.msg_valid & ni.msg_ready;
  assign data_fire = ni.data_valid & ni.data_ready;
  assign out_fire  = vld_q & ni.flit_out_ready;
  assign last      = (cnt_q == len_q - ONE_L);
  assign eff_len   = (ni.msg_len > MAX_L) ? MAX_L : ni.msg_len;

  assign busy         = (state != IDLE) | vld_q;
  assign err_len_zero = err_q;

  // A 1-word message is SINGLE even though it is both first and last.
  always_comb begin
    if (len_q == ONE_L)      ftype = FLIT_SINGLE;
    else if (cnt_q == '0)    ftype = FLIT_HEAD;
    else if (last)           ftype = FLIT_TAIL;
    else                     ftype = FLIT_BODY;
  end

  always_comb begin
    nxt           = '0;
    nxt.flit_type = ftype;
    nxt.vc_id     = vc_q;
    nxt.qos       = qos_q;
    nxt.src_x     = SRC_X;
    nxt.src_y     = SRC_Y;
    nxt.dst_x     = dst_x_q;
    nxt.dst_y     = dst_y_q;
    nxt.packet_id = pid_q;
    nxt.seq_num   = SEQ_NUM_WIDTH'(cnt_q);
    nxt.payload   = ni.data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      dst_x_q <= '0;
      dst_y_q <= '0;
      vc_q    <= '0;
      qos_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      pid_q   <= '0;
      flit_q  <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= msg_fire & (ni.msg_len == '0);
      if (out_fire) vld_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (msg_fire && ni.msg_len != '0) begin
            dst_x_q <= ni.msg_dest_x;
            dst_y_q <= ni.msg_dest_y;
            vc_q    <= ni.msg_vc_id;
            qos_q   <= ni.msg_qos;
            len_q   <= eff_len;
            cnt_q   <= '0;
            state   <= STREAM;
          end
        end
        STREAM: begin
          if (data_fire) begin
            flit_q <= nxt;
            vld_q  <= 1'b1;
            cnt_q  <= cnt_q + ONE_L;
            if (last) begin
              pid_q <= pid_q + ONE_P;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef NEBULA_NI_STATS_EN
  localparam logic [PERF_COUNTER_WIDTH-1:0] ONE_C =
    PERF_COUNTER_WIDTH'(1);

  logic is_end;
  assign is_end = (flit_q.flit_type == FLIT_TAIL) |
                  (flit_q.flit_type == FLIT_SINGLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      pkts_sent  <= '0;
      flits_sent <= '0;
    end else if (out_fire) begin
      if (flits_sent != '1) flits_sent <= flits_sent + ONE_C;
      if (is_end && pkts_sent != '1)
        pkts_sent <= pkts_sent + ONE_C;
    end
  end
`endif

endmodule

// File: tb/tb_nebula_ni_packetizer.sv
// Scoreboard bench for nebula_ni_packetizer with a message-level model.
// Covers latency, backpressure, zero/clamped lengths, pid wrap and reset.
module tb_nebula_ni_packetizer;
  import nebula_pkg::*;

  localparam logic [3:0] SX = 4'd2;
  localparam logic [3:0] SY = 4'd3;
  localparam int MAX_LEN = 16;
  localparam int LW = 5;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  logic err_len_zero;
`ifdef NEBULA_NI_STATS_EN
  logic [PERF_COUNTER_WIDTH-1:0] pkts_sent;
  logic [PERF_COUNTER_WIDTH-1:0] flits_sent;
`endif

  always #5 clk = ~clk;

  nebula_ni_packetizer_if #(.LEN_WIDTH(LW)) ni ();

  nebula_ni_packetizer #(
    .SRC_X(SX), .SRC_Y(SY),
    .MAX_LEN(MAX_LEN), .LEN_WIDTH(LW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ni(ni),
    .busy(busy),
    .err_len_zero(err_len_zero)
`ifdef NEBULA_NI_STATS_EN
    ,
    .pkts_sent(pkts_sent),
    .flits_sent(flits_sent)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;
  noc_flit_t exp_q[$];
  logic [7:0] m_pid;
  int hs_flits;
  int hs_pkts;
  bit rnd_rdy;

  task automatic chk1(string nm, logic act, logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk_int(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_flit(string nm, noc_flit_t act,
                          noc_flit_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Flit n of an eff-word message as the packet format defines it.
  function automatic noc_flit_t mk(int eff, int i,
      logic [3:0] dx, logic [3:0] dy, vc_id_t vc, qos_t q,
      logic [7:0] pid, logic [31:0] pl);
    noc_flit_t f;
    f = '0;
    if (eff == 1)          f.flit_type = FLIT_SINGLE;
    else if (i == 0)       f.flit_type = FLIT_HEAD;
    else if (i == eff - 1) f.flit_type = FLIT_TAIL;
    else                   f.flit_type = FLIT_BODY;
    f.vc_id = vc;
    f.qos = q;
    f.src_x = SX;
    f.src_y = SY;
    f.dst_x = dx;
    f.dst_y = dy;
    f.packet_id = pid;
    f.seq_num = SEQ_NUM_WIDTH'(i);
    f.payload = pl;
    return f;
  endfunction

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_msg_hs();
    int k;
    k = 0;
    forever begin
      @(negedge clk);
      if (ni.msg_ready) break;
      k++;
      if (k > 1000) begin
        $display("FAIL msg_hs_timeout: got stall expected ready");
        $fatal(1);
      end
    end
    align();
  endtask

  task automatic wait_data_hs();
    int k;
    k = 0;
    forever begin
      @(negedge clk);
      if (ni.data_ready) break;
      k++;
      if (k > 1000) begin
        $display("FAIL data_hs_timeout: got stall expected ready");
        $fatal(1);
      end
    end
    align();
  endtask

  // Called at posedge+1; returns at posedge+1 after the last handshake.
  task automatic send_msg(input logic [3:0] dx, input logic [3:0] dy,
      input vc_id_t vc, input qos_t q, input int len,
      input logic [31:0] d0, input bit inc, input bit gaps);
    int eff;
    logic [31:0] w[$];
    eff = (len > MAX_LEN) ? MAX_LEN : len;
    for (int i = 0; i < eff; i++)
      w.push_back(inc ? d0 + 32'(i) : $urandom);
    for (int i = 0; i < eff; i++)
      exp_q.push_back(mk(eff, i, dx, dy, vc, q, m_pid, w[i]));
    if (eff > 0) m_pid = m_pid + 8'd1;
    ni.msg_valid = 1'b1;
    ni.msg_dest_x = dx;
    ni.msg_dest_y = dy;
    ni.msg_vc_id = vc;
    ni.msg_qos = q;
    ni.msg_len = LW'(len);
    wait_msg_hs();
    ni.msg_valid = 1'b0;
    for (int i = 0; i < eff; i++) begin
      if (gaps && $urandom_range(3) == 0) align();
      ni.data_valid = 1'b1;
      ni.data = w[i];
      wait_data_hs();
      ni.data_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((exp_q.size() > 0 || ni.flit_out_valid) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk_int("drain", exp_q.size(), 0);
    align();
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rst && ni.flit_out_valid && ni.flit_out_ready) begin
        hs_flits++;
        if (ni.flit_out.flit_type == FLIT_TAIL ||
            ni.flit_out.flit_type == FLIT_SINGLE) hs_pkts++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_flit: got %h expected none",
                   ni.flit_out);
        end else begin
          chk_flit("flit", ni.flit_out, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_rdy) ni.flit_out_ready = ($urandom_range(3) != 0);
    end
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1);
  end

  initial begin
    noc_flit_t held;
    int k;
    rst = 1'b1;
    rnd_rdy = 1'b0;
    m_pid = '0;
    hs_flits = 0;
    hs_pkts = 0;
    ni.msg_valid = 1'b0;
    ni.msg_dest_x = '0;
    ni.msg_dest_y = '0;
    ni.msg_vc_id = '0;
    ni.msg_qos = '0;
    ni.msg_len = '0;
    ni.data_valid = 1'b0;
    ni.data = '0;
    ni.flit_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk1("rst_valid", ni.flit_out_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_err", err_len_zero, 1'b0);
    chk1("rst_msg_ready", ni.msg_ready, 1'b1);
    chk1("rst_data_ready", ni.data_ready, 1'b0);
    chk_flit("rst_flit", ni.flit_out, '0);
    align();

    // Single-word message: valid exactly two edges after msg_valid.
    fork
      send_msg(4'd1, 4'd1, 2'd1, 2'd2, 1, 32'hA5, 1'b1, 1'b0);
      begin
        @(negedge clk);
        chk1("lat_edge0", ni.flit_out_valid, 1'b0);
        @(negedge clk);
        chk1("lat_edge1", ni.flit_out_valid, 1'b0);
        @(negedge clk);
        chk1("lat_edge2", ni.flit_out_valid, 1'b1);
      end
    join
    drain();

    send_msg(4'd0, 4'd3, 2'd0, 2'd1, 4, 32'd1, 1'b1, 1'b0);
    send_msg(4'd3, 4'd0, 2'd3, 2'd0, 2, 32'd50, 1'b1, 1'b0);
    drain();

    // HEAD must sit unchanged under backpressure.
    ni.flit_out_ready = 1'b0;
    fork
      send_msg(4'd2, 4'd2, 2'd2, 2'd3, 3, 32'd100, 1'b1, 1'b0);
      begin
        k = 0;
        do begin
          @(negedge clk);
          k++;
        end while (!ni.flit_out_valid && k < 100);
        held = ni.flit_out;
        chk_int("bp_head", int'(held.flit_type), int'(FLIT_HEAD));
        repeat (5) begin
          @(negedge clk);
          chk_flit("bp_hold", ni.flit_out, held);
          chk1("bp_data_ready", ni.data_ready, 1'b0);
        end
        align();
        ni.flit_out_ready = 1'b1;
      end
    join
    drain();

    send_msg(4'd1, 4'd2, 2'd0, 2'd0, 0, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk1("len0_err", err_len_zero, 1'b1);
    chk1("len0_valid", ni.flit_out_valid, 1'b0);
    @(negedge clk);
    chk1("len0_err_pulse", err_len_zero, 1'b0);
    align();

    send_msg(4'd3, 4'd3, 2'd1, 2'd1, 20, 32'd0, 1'b0, 1'b0);
    drain();

    rnd_rdy = 1'b1;
    for (int i = 0; i < 257; i++)
      send_msg(4'($urandom), 4'($urandom), vc_id_t'($urandom),
               qos_t'($urandom), 1, 32'd0, 1'b0, 1'b1);
    for (int i = 0; i < 40; i++)
      send_msg(4'($urandom), 4'($urandom), vc_id_t'($urandom),
               qos_t'($urandom), $urandom_range(20), 32'd0,
               1'b0, 1'b1);
    drain();
    rnd_rdy = 1'b0;
    align();
    ni.flit_out_ready = 1'b1;

`ifdef NEBULA_NI_STATS_EN
    chk_int("stat_flits", int'(flits_sent), hs_flits);
    chk_int("stat_pkts", int'(pkts_sent), hs_pkts);
`endif

    // Reset right after the BODY handshake of a 4-word message.
    for (int i = 0; i < 4; i++)
      exp_q.push_back(mk(4, i, 4'd1, 4'd0, 2'd2, 2'd1, m_pid,
                         32'd11 + 32'(i)));
    ni.msg_valid = 1'b1;
    ni.msg_dest_x = 4'd1;
    ni.msg_dest_y = 4'd0;
    ni.msg_vc_id = 2'd2;
    ni.msg_qos = 2'd1;
    ni.msg_len = LW'(4);
    align();
    ni.msg_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ni.data_valid = 1'b1;
      ni.data = 32'd11 + 32'(i);
      align();
    end
    chk_int("rst_mid_left", exp_q.size(), 2);
    rst = 1'b1;
    ni.data_valid = 1'b0;
    align();
    rst = 1'b0;
    exp_q.delete();
    m_pid = '0;
    hs_flits = 0;
    hs_pkts = 0;
    @(negedge clk);
    chk1("rst_mid_valid", ni.flit_out_valid, 1'b0);
    chk1("rst_mid_busy", busy, 1'b0);
    chk1("rst_mid_idle", ni.msg_ready, 1'b1);
    align();
    send_msg(4'd0, 4'd1, 2'd0, 2'd3, 4, 32'd70, 1'b1, 1'b0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
